i2s_rx: RTL and testbench

- Receive-side I2S deserializer; the counterpart of the core's I2S audio transmitter.
- Takes an external serial stream (BCK/LRCK/DATA from an ADC or a second board) into the system clock domain by oversampling.
- Outputs parallel left/right samples with a frame strobe, for the audio mixer behind the optional audio-input path.
- BCK must be at most clk/4.

---
 rtl/i2s_pkg.sv | 14 +
 rtl/sync_edge.sv | 33 +++
 rtl/i2s_rx.sv | 156 +++++++++++++++
 tb/tb_i2s_rx.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// i2s_pkg: shared I2S types and constants for the audio receive/transmit path.
package i2s_pkg;

  localparam int SAMPLE_W = 16;
  localparam int SLOT_LEN_DEFAULT = 32;

  typedef logic [SAMPLE_W-1:0] sample_t;

  typedef enum logic {
    LEFT  = 1'b0,
    RIGHT = 1'b1
  } chan_t;

endpackage

// File: rtl/sync_edge.sv
// sync_edge: multi-stage input synchronizer with a rising-edge strobe.
module sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic rise
);

  logic [STAGES-1:0] ff_q, ff_d;
  logic              prev_q, prev_d;

  always_comb begin
    ff_d   = {ff_q[STAGES-2:0], d};
    prev_d = ff_q[STAGES-1];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ff_q   <= '0;
      prev_q <= 1'b0;
    end else begin
      ff_q   <= ff_d;
      prev_q <= prev_d;
    end
  end

  assign q    = ff_q[STAGES-1];
  assign rise = ff_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/i2s_rx.sv
// i2s_rx: oversampling I2S receiver producing parallel stereo sample pairs.
// Define I2S_RX_LJ_EN to add the lj_mode input for left-justified streams.
module i2s_rx
  import i2s_pkg::*;
#(
  parameter int AUDIO_DW    = SAMPLE_W,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i2s_bck,
  input  logic                i2s_lrck,
  input  logic                i2s_data,
`ifdef I2S_RX_LJ_EN
  input  logic                lj_mode,
`endif
  output logic [AUDIO_DW-1:0] left,
  output logic [AUDIO_DW-1:0] right,
  output logic                sample_valid,
  output logic                locked
);

  localparam logic [CNT_W:0]   DW_W    = (CNT_W+1)'(AUDIO_DW);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic bck_rise, ws_s, d_s;
  logic unused_bck_q, unused_ws_rise, unused_d_rise;

  sync_edge #(.STAGES(SYNC_STAGES)) u_bck (
    .clk  (clk),
    .reset(reset),
    .d    (i2s_bck),
    .q    (unused_bck_q),
    .rise (bck_rise)
  );

  sync_edge #(.STAGES(SYNC_STAGES)) u_ws (
    .clk  (clk),
    .reset(reset),
    .d    (i2s_lrck),
    .q    (ws_s),
    .rise (unused_ws_rise)
  );

  sync_edge #(.STAGES(SYNC_STAGES)) u_data (
    .clk  (clk),
    .reset(reset),
    .d    (i2s_data),
    .q    (d_s),
    .rise (unused_d_rise)
  );

  chan_t               ws_prev_q, ws_prev_d;
  logic [AUDIO_DW-1:0] sr_q, sr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                locked_q, locked_d;
  logic [AUDIO_DW-1:0] pend_q, pend_d;
  logic [AUDIO_DW-1:0] left_q, left_d;
  logic [AUDIO_DW-1:0] right_q, right_d;
  logic                pair_q, pair_d;
  logic                valid_q, valid_d;

  logic [AUDIO_DW-1:0] sr_sh, word;
  logic [CNT_W-1:0]    cnt_inc;
  logic                done;

  // Left-justify the captured bits; short words are zero-padded.
  function automatic logic [AUDIO_DW-1:0] justify(
    input logic [AUDIO_DW-1:0] s,
    input logic [CNT_W:0]      n
  );
    logic [CNT_W:0] k;
    k = (n > DW_W) ? DW_W : n;
    return s << (DW_W - k);
  endfunction

  always_comb begin
    ws_prev_d = ws_prev_q;
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    locked_d  = locked_q;
    pend_d    = pend_q;
    left_d    = left_q;
    right_d   = right_q;
    pair_d    = 1'b0;
    valid_d   = pair_q;
    done      = 1'b0;
    word      = '0;
    sr_sh     = ({1'b0, cnt_q} < DW_W) ?
                {sr_q[AUDIO_DW-2:0], d_s} : sr_q;
    cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + CNT_ONE;
    if (bck_rise) begin
      ws_prev_d = chan_t'(ws_s);
      if (chan_t'(ws_s) == ws_prev_q) begin
        sr_d  = sr_sh;
        cnt_d = cnt_inc;
      end else begin
        done  = 1'b1;
        word  = justify(sr_sh, {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1});
        sr_d  = '0;
        cnt_d = '0;
`ifdef I2S_RX_LJ_EN
        if (lj_mode) begin
          word  = justify(sr_q, {1'b0, cnt_q});
          sr_d  = {{(AUDIO_DW-1){1'b0}}, d_s};
          cnt_d = CNT_ONE;
        end
`endif
      end
    end
    if (done) begin
      if (!locked_q) begin
        locked_d = 1'b1;
      end else if (ws_prev_q == LEFT) begin
        pend_d = word;
      end else begin
        left_d  = pend_q;
        right_d = word;
        pair_d  = 1'b1;
      end
    end
  end

  // Starting as RIGHT makes the first LRCK-low bit a word boundary,
  // so a stream entering at a left slot locks before that slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ws_prev_q <= RIGHT;
      sr_q      <= '0;
      cnt_q     <= '0;
      locked_q  <= 1'b0;
      pend_q    <= '0;
      left_q    <= '0;
      right_q   <= '0;
      pair_q    <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      ws_prev_q <= ws_prev_d;
      sr_q      <= sr_d;
      cnt_q     <= cnt_d;
      locked_q  <= locked_d;
      pend_q    <= pend_d;
      left_q    <= left_d;
      right_q   <= right_d;
      pair_q    <= pair_d;
      valid_q   <= valid_d;
    end
  end

  assign left         = left_q;
  assign right        = right_q;
  assign sample_valid = valid_q;
  assign locked       = locked_q;

endmodule

// File: tb/tb_i2s_rx.sv
// tb_i2s_rx: scoreboard bench for i2s_rx (I2S frames, slot lengths, reset, hold).
// Define I2S_RX_LJ_EN to also exercise the left-justified input mode.
module tb_i2s_rx;

  localparam int HALF = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        i2s_bck;
  logic        i2s_lrck;
  logic        i2s_data;
  logic [15:0] left;
  logic [15:0] right;
  logic        sample_valid;
  logic        locked;
`ifdef I2S_RX_LJ_EN
  logic        lj_mode;
`endif

  typedef struct packed {
    logic [15:0] l;
    logic [15:0] r;
  } pair_t;

  pair_t       exp_q[$];
  pair_t       mon_e;
  int          checks = 0;
  int          errors = 0;
  int          pulses = 0;
  int          p0;
  logic [31:0] lv, rv;

  always #5 clk = ~clk;

  i2s_rx dut (
    .clk         (clk),
    .reset       (reset),
    .i2s_bck     (i2s_bck),
    .i2s_lrck    (i2s_lrck),
    .i2s_data    (i2s_data),
`ifdef I2S_RX_LJ_EN
    .lj_mode     (lj_mode),
`endif
    .left        (left),
    .right       (right),
    .sample_valid(sample_valid),
    .locked      (locked)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] just(input logic [31:0] v, input int s);
    logic [31:0] t;
    t = (s >= 16) ? (v >> (s - 16)) : (v << (16 - s));
    return t[15:0];
  endfunction

  task automatic expect_pair(input logic [15:0] l, input logic [15:0] r);
    exp_q.push_back({l, r});
  endtask

  task automatic send_bit(input logic ws, input logic d);
    i2s_lrck = ws;
    i2s_data = d;
    repeat (HALF) @(negedge clk);
    i2s_bck = 1'b1;
    repeat (HALF) @(negedge clk);
    i2s_bck = 1'b0;
  endtask

  task automatic send_frame(input logic [31:0] l, input logic [31:0] r,
                            input int s, input bit lj);
    logic d, ws;
    for (int p = 0; p < 2*s; p++) begin
      d  = (p < s) ? l[s-1-p] : r[2*s-1-p];
      ws = lj ? (p >= s) : (p >= s-1 && p < 2*s-1);
      send_bit(ws, d);
    end
  endtask

  task automatic drain(input string tag);
    repeat (20) @(negedge clk);
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_left"}, 32'(left), 32'd0);
    check({tag, "_right"}, 32'(right), 32'd0);
    check({tag, "_valid"}, 32'(sample_valid), 32'd0);
    check({tag, "_locked"}, 32'(locked), 32'd0);
  endtask

  always @(negedge clk) begin
    if (!reset && sample_valid) begin
      pulses++;
      if (exp_q.size() == 0) begin
        check("spurious_pulse", 32'(sample_valid), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("left", 32'(left), 32'(mon_e.l));
        check("right", 32'(right), 32'(mon_e.r));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    reset    = 1'b1;
    i2s_bck  = 1'b0;
    i2s_lrck = 1'b0;
    i2s_data = 1'b0;
`ifdef I2S_RX_LJ_EN
    lj_mode  = 1'b0;
`endif
    repeat (5) @(negedge clk);
    check_zero("rst");
    reset = 1'b0;
    repeat (3) @(negedge clk);

    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      expect_pair(16'h1234, 16'hABCD);
      send_frame(32'h1234_0000, 32'hABCD_0000, 32, 1'b0);
    end
    drain("drain_32");
    check("pulses_32", 32'(pulses), 32'd3);
    check("locked_32", 32'(locked), 32'd1);

    lv = 32'hA5;
    rv = 32'h5A;
    expect_pair(just(lv, 8), just(rv, 8));
    send_frame(lv, rv, 8, 1'b0);
    drain("drain_8");

    lv = 32'h7F_FFFF;
    rv = 32'h80_0001;
    expect_pair(just(lv, 24), just(rv, 24));
    send_frame(lv, rv, 24, 1'b0);
    drain("drain_24");

    p0 = pulses;
    for (int i = 0; i < 6; i++) begin
      i2s_lrck = ~i2s_lrck;
      repeat (100) @(negedge clk);
    end
    repeat (400) @(negedge clk);
    check("hold_pulses", 32'(pulses - p0), 32'd0);
    check("hold_left", 32'(left), 32'h7FFF);
    check("hold_right", 32'(right), 32'h8000);
    check("hold_locked", 32'(locked), 32'd1);

    for (int i = 0; i < 2; i++) begin
      lv = $urandom;
      rv = $urandom;
      expect_pair(lv[15:0], rv[15:0]);
      send_frame(lv, rv, 16, 1'b0);
    end
    drain("drain_rand");

    lv = 32'h1111_0000;
    rv = 32'h2222_0000;
    for (int p = 0; p < 32; p++) send_bit(p == 31, lv[31-p]);
    for (int p = 0; p < 10; p++) send_bit(1'b1, rv[31-p]);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_zero("midrst");
    reset = 1'b0;
    repeat (3) @(negedge clk);
    p0 = pulses;
    for (int p = 10; p < 32; p++) send_bit(p != 31, rv[31-p]);
    repeat (20) @(negedge clk);
    check("midrst_nopulse", 32'(pulses - p0), 32'd0);
    expect_pair(16'h0F0F, 16'hF0F0);
    send_frame(32'h0F0F_0000, 32'hF0F0_0000, 32, 1'b0);
    expect_pair(16'h0001, 16'hFFFE);
    send_frame(32'h0001_FFFF, 32'hFFFE_0000, 32, 1'b0);
    drain("drain_midrst");
    check("midrst_pulses", 32'(pulses - p0), 32'd2);

`ifdef I2S_RX_LJ_EN
    reset = 1'b1;
    lj_mode = 1'b1;
    i2s_lrck = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    expect_pair(16'h8001, 16'h0002);
    send_frame(32'h8001, 32'h0002, 16, 1'b1);
    send_bit(1'b0, 1'b0);
    drain("drain_lj1");

    reset = 1'b1;
    lj_mode = 1'b0;
    i2s_lrck = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    expect_pair(16'h0002, 16'h0004);
    send_frame(32'h8001, 32'h0002, 16, 1'b1);
    send_bit(1'b0, 1'b0);
    drain("drain_lj0");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
